vga_renderer: RTL

- Display back end fed by the memory-mapped I/O block's 10-word VRAM output bus.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Draws up to 10 prioritised solid-colour rectangles (bird, pipes, ground, score bars) over a background colour.
- Drives the vsync line that the I/O block latches as the CPU-visible refresh flag.

---
 rtl/vga_renderer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_renderer.sv
// VGA timing generator with a 10-entry prioritised rectangle compositor.
// Optional 1-px white object outline: define VGA_RENDERER_BORDER_EN.
module vga_renderer #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic [23:0] BG_COLOR  = 24'h4EC0CA
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0][31:0] vram_output,
   output logic             vga_clk,
   output logic             hsync,
   output logic             vsync,
   output logic             blank_n,
   output logic             sync_n,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic             frame_start
);

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned CRD_W    = 11;
   localparam int unsigned N_OBJ    = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_VISIBLE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic                        tick_q, tick_d;
   logic [CNT_W-1:0]            h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0]            v_cnt_q, v_cnt_d;
   logic [N_OBJ-1:0][31:0]      shadow_q, shadow_d;
   logic                        hsync_q, hsync_d;
   logic                        vsync_q, vsync_d;
   logic                        blank_n_q, blank_n_d;
   logic                        frame_start_q, frame_start_d;
   logic [23:0]                 rgb_q, rgb_d;

   logic [23:0]                 pix_rgb;
   logic                        found;
   logic                        visible;
   logic [31:0]                 obj;
   logic [CRD_W-1:0]            hx, vy, x_lo, x_hi, y_lo, y_hi;

   // Object lookup for the current pixel against the shadow copy; lowest index wins.
   always_comb begin
      pix_rgb = BG_COLOR;
      found   = 1'b0;
      obj     = '0;
      x_lo    = '0;
      x_hi    = '0;
      y_lo    = '0;
      y_hi    = '0;
      hx      = CRD_W'(h_cnt_q);
      vy      = CRD_W'(v_cnt_q);
      for (int i = 0; i < N_OBJ; i++) begin
         obj  = shadow_q[i];
         x_lo = CRD_W'(obj[27:18]);
         x_hi = x_lo + CRD_W'({obj[8:4], 3'b000});
         y_lo = CRD_W'(obj[17:9]);
         y_hi = y_lo + CRD_W'({obj[3:0], 5'b00000});
         if (!found && obj[31] && hx >= x_lo && hx < x_hi && vy >= y_lo && vy < y_hi) begin
            found   = 1'b1;
            pix_rgb = {{8{obj[30]}}, {8{obj[29]}}, {8{obj[28]}}};
`ifdef VGA_RENDERER_BORDER_EN
            if (hx == x_lo || hx == x_hi - CRD_W'(1) || vy == y_lo || vy == y_hi - CRD_W'(1))
               pix_rgb = 24'hFFFFFF;
`endif
         end
      end
   end

   // Counters, shadow capture and the single output pipeline stage, all gated by tick.
   always_comb begin
      tick_d        = ~tick_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      shadow_d      = shadow_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      blank_n_d     = blank_n_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      visible       = (h_cnt_q < CNT_W'(H_VISIBLE)) && (v_cnt_q < CNT_W'(V_VISIBLE));
      if (tick_q) begin
         if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
         end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
         end
         if (h_cnt_q == '0 && v_cnt_q == CNT_W'(V_VISIBLE))
            shadow_d = vram_output;
         hsync_d       = !(h_cnt_q >= CNT_W'(HS_START) && h_cnt_q < CNT_W'(HS_END));
         vsync_d       = !(v_cnt_q >= CNT_W'(VS_START) && v_cnt_q < CNT_W'(VS_END));
         blank_n_d     = visible;
         rgb_d         = visible ? pix_rgb : 24'h000000;
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q        <= 1'b0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         shadow_q      <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         shadow_q      <= shadow_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_clk     = tick_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_n_q;
   assign sync_n      = 1'b0;
   assign r           = rgb_q[23:16];
   assign g           = rgb_q[15:8];
   assign b           = rgb_q[7:0];
   assign frame_start = frame_start_q;

endmodule
